dmem_ext_target: RTL
====================

Name: dmem_ext_target

Overview:
- Data-memory responder for the CPU driver's external loader bus (Ext_MemWrite / Ext_DataAdr / Ext_WriteData) and for the CPU data port (MemWrite / DataAdr / WriteData / ReadData).
- While the driver holds the CPU in reset, the loader owns the memory. After release, the CPU owns it.
- A CPU store to a memory-mapped RESULT_ADDR is captured and flagged back to the driver as result/result_valid.

Parameters:
- DEPTH, 64, number of 32-bit words in the array.
- ADDR_W, 6, word-index width; must equal log2(DEPTH).
- RESULT_ADDR, 32'h0000_0100, byte address of the result register; must lie outside 0..4*DEPTH-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- cpu_hold  in  1  CPU reset as driven by the driver; 1 = loader owns memory.
- Ext_MemWrite  in  1  loader write strobe.
- Ext_DataAdr  in  32  loader byte address.
- Ext_WriteData  in  32  loader write data.
- MemWrite  in  1  CPU write strobe.
- DataAdr  in  32  CPU byte address.
- WriteData  in  32  CPU write data.
- ReadData  out  32  CPU read data.
- result  out  32  last value the CPU stored to RESULT_ADDR.
- result_valid  out  1  result captured since the last hold.
- load_count  out  ADDR_W+1  count of accepted loader writes since the last hold entry.
- ext_err  out  1  sticky loader-protocol error.

Behaviour:
- Addressing:
  - Word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
  - In range iff addr < 4*DEPTH.
  - The memory array is not cleared by reset.
- Ownership follows the current-cycle cpu_hold level:
  - cpu_hold=1: Ext writes go to memory; CPU MemWrite ignored.
  - cpu_hold=0: CPU writes go to memory; Ext writes dropped.
- ReadData:
  - Combinational mem[index of DataAdr], zero-latency (single-cycle CPU).
  - Forced to 0 when reset=1, cpu_hold=1, or DataAdr is out of range.
  - Reading RESULT_ADDR returns result.
- Writes commit at the clock edge and are visible on ReadData the next cycle. Same-address read and write in one cycle returns the old data.
- FSM states: HOLD, RUN, DONE.
  - reset → HOLD.
  - HOLD → RUN on the first edge with cpu_hold=0.
  - RUN → DONE on an accepted CPU write with DataAdr==RESULT_ADDR.
  - Any state → HOLD on an edge with cpu_hold=1 (includes mid-run re-hold).
  - In DONE, further RESULT_ADDR stores update result; result_valid stays 1.
- result:
  - Reset 0.
  - Loads WriteData on a CPU write to RESULT_ADDR while cpu_hold=0.
  - Not cleared by HOLD, so the driver can read it after re-holding.
- result_valid:
  - Reset 0.
  - Goes to 1 the cycle after the capturing write.
  - Cleared on any edge with cpu_hold=1.
- load_count:
  - Reset 0; cleared on the HOLD entry edge (RUN/DONE→HOLD).
  - +1 per accepted in-range Ext write while cpu_hold=1.
  - Saturates at DEPTH.
  - If the clear edge coincides with an accepted write, the result is 1.
- ext_err:
  - Reset 0; cleared only by reset.
  - Set on an Ext_MemWrite while cpu_hold=0.
  - Set on an Ext_MemWrite to an out-of-range address while cpu_hold=1.
  - The offending write is dropped.
- CPU out-of-range writes other than RESULT_ADDR are dropped silently.
- Reset asserted mid-operation:
  - All registers return to reset values.
  - Writes presented in that cycle are dropped.
  - Memory contents are retained.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- Defined:
  - Adds output load_sum (32 bits): modulo-2^32 sum of Ext_WriteData over accepted loader writes.
  - Same clear/reset rules as load_count; no saturation.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, cpu_hold=1; load 0x11,0x22,0x33 to 0x0,0x4,0x8 → load_count=3, ext_err=0; with LOAD_CHECKSUM_EN, load_sum=0x66.
- Release hold; DataAdr=0x4 → ReadData=0x22. CPU write 0xAB to 0x8 → next cycle ReadData(0x8)=0xAB.
- CPU write 0x0000_00C5 to 0x100 → result=0xC5, result_valid=1 the next cycle, FSM=DONE. Raise cpu_hold → result_valid=0, result still 0xC5, load_count=0.
- Ext write while cpu_hold=0, and Ext write to 0x200 while held → memory unchanged, ext_err=1 and stays 1 until reset.
- Write 64 in-range words plus 2 more while held → load_count saturates at 64. A CPU MemWrite while held leaves memory unchanged.
- Assert reset the same cycle as a CPU write to 0x100 → result=0, result_valid=0, FSM=HOLD; previously loaded word at 0x0 still reads 0x11 after release.

Source files
------------

// File: rtl/dmem_ext_target.sv
// Data memory shared between the driver's loader bus (while the CPU is held) and the CPU data port.
// Optional LOAD_CHECKSUM_EN adds load_sum, a running sum of accepted loader write data.
//
// state | meaning
// HOLD  | CPU held in reset, loader owns memory
// RUN   | CPU running, no result stored yet
// DONE  | CPU has stored to RESULT_ADDR at least once
module dmem_ext_target #(
    parameter int          DEPTH       = 64,
    parameter int          ADDR_W      = 6,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_hold,
    input  logic              Ext_MemWrite,
    input  logic [31:0]       Ext_DataAdr,
    input  logic [31:0]       Ext_WriteData,
    input  logic              MemWrite,
    input  logic [31:0]       DataAdr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic [31:0]       result,
    output logic              result_valid,
    output logic [ADDR_W:0]   load_count,
    output logic              ext_err
`ifdef LOAD_CHECKSUM_EN
    ,output logic [31:0]      load_sum
`endif
);

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [31:0]     BYTE_LIMIT = 32'(4 * DEPTH);
    localparam logic [ADDR_W:0] COUNT_MAX  = (ADDR_W + 1)'(DEPTH);

    state_t state, state_nxt;

    logic [31:0] mem [DEPTH];

    logic              ext_in_range;
    logic              cpu_in_range;
    logic [ADDR_W-1:0] ext_idx;
    logic [ADDR_W-1:0] cpu_idx;
    logic              ext_accept;
    logic              cpu_mem_wr;
    logic              cpu_res_wr;
    logic              ext_bad;
    logic              hold_entry;

    assign ext_in_range = (Ext_DataAdr < BYTE_LIMIT);
    assign cpu_in_range = (DataAdr < BYTE_LIMIT);
    assign ext_idx      = Ext_DataAdr[ADDR_W+1:2];
    assign cpu_idx      = DataAdr[ADDR_W+1:2];

    assign ext_accept = cpu_hold && Ext_MemWrite && ext_in_range;
    assign cpu_mem_wr = !cpu_hold && MemWrite && cpu_in_range;
    assign cpu_res_wr = !cpu_hold && MemWrite && (DataAdr == RESULT_ADDR);
    assign ext_bad    = Ext_MemWrite && (!cpu_hold || !ext_in_range);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (cpu_hold) begin
            state_nxt = HOLD;
        end else begin
            case (state)
                HOLD:    state_nxt = RUN;
                RUN:     state_nxt = cpu_res_wr ? DONE : RUN;
                DONE:    state_nxt = DONE;
                default: state_nxt = HOLD;
            endcase
        end
    end

    // Output logic: hold entry is the RUN/DONE -> HOLD edge
    always_comb begin
        hold_entry = 1'b0;
        case (state)
            RUN, DONE: hold_entry = cpu_hold;
            default:   hold_entry = 1'b0;
        endcase
    end

    // Array has no reset; contents survive reset and re-hold
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (ext_accept) begin
                mem[ext_idx] <= Ext_WriteData;
            end else if (cpu_mem_wr) begin
                mem[cpu_idx] <= WriteData;
            end
        end
    end

    always_comb begin
        ReadData = 32'h0;
        if (!reset && !cpu_hold) begin
            if (DataAdr == RESULT_ADDR) begin
                ReadData = result;
            end else if (cpu_in_range) begin
                ReadData = mem[cpu_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result       <= 32'h0;
            result_valid <= 1'b0;
        end else begin
            if (cpu_res_wr) begin
                result <= WriteData;
            end
            if (cpu_hold) begin
                result_valid <= 1'b0;
            end else if (cpu_res_wr) begin
                result_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_count <= '0;
            ext_err    <= 1'b0;
        end else begin
            if (hold_entry) begin
                load_count <= ext_accept ? (ADDR_W + 1)'(1) : '0;
            end else if (ext_accept && (load_count < COUNT_MAX)) begin
                load_count <= load_count + 1'b1;
            end
            if (ext_bad) begin
                ext_err <= 1'b1;
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            load_sum <= 32'h0;
        end else if (hold_entry) begin
            load_sum <= ext_accept ? Ext_WriteData : 32'h0;
        end else if (ext_accept) begin
            load_sum <= load_sum + Ext_WriteData;
        end
    end
`endif

endmodule
